tlp_ingress_router: RTL and testbench

Upstream ingress stage for the PCIe transaction layer. It accepts a single 10-bit word stream over a valid/ready handshake and decodes the destination lane from bits [9:8]. It holds each word in a one-entry stage register and pushes it into the matching input FIFO (lanes 0–3), honouring each FIFO's almost-full backpressure. It also keeps per-lane push counters that can be read with a req/idx strobe, in the same style as the downstream counter block.

---
 rtl/tlp_ingress_router_pkg.sv | 19 +
 rtl/tlp_ingress_router_if.sv | 30 +++
 rtl/tlp_ingress_router_lane_push_counter.sv | 36 +++
 rtl/tlp_ingress_router.sv | 96 +++++++++
 tb/tb_tlp_ingress_router.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/tlp_ingress_router_pkg.sv
// tl_pkg: constants and types shared by the transaction-layer ingress router.
//   DEF_DATA_WIDTH      default stream word width
//   LANE_MSB/LANE_LSB   position of the destination-lane field in a word
//   N_LANES             number of downstream input FIFOs
//   rtr_state_e         routing FSM state encoding (also exported for debug)
package tl_pkg;

  localparam int DEF_DATA_WIDTH = 10;
  localparam int LANE_MSB       = 9;
  localparam int LANE_LSB       = 8;
  localparam int N_LANES        = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } rtr_state_e;

endpackage

// File: rtl/tlp_ingress_router_if.sv
// Bus bundle for tlp_ingress_router.
//   in_valid/in_data/in_ready   upstream word stream (valid/ready)
//   alm_full/push_out/data_out  input-FIFO side: backpressure, push strobes, shared data
//   req/idx/cnt_out/cnt_valid   per-lane push counter readback
// Modports: slave = router view, master = environment driving the router.
interface tlp_ingress_router_if #(
  parameter int DATA_WIDTH = 10,
  parameter int CNT_WIDTH  = 5
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic [3:0]            alm_full;
  logic [3:0]            push_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  req;
  logic [1:0]            idx;
  logic [CNT_WIDTH-1:0]  cnt_out;
  logic                  cnt_valid;

  modport slave (
    input  in_valid, in_data, alm_full, req, idx,
    output in_ready, push_out, data_out, cnt_out, cnt_valid
  );

  modport master (
    output in_valid, in_data, alm_full, req, idx,
    input  in_ready, push_out, data_out, cnt_out, cnt_valid
  );
endinterface

// File: rtl/tlp_ingress_router_lane_push_counter.sv
// lane_push_counter: four wrapping push counters with registered readback.
//   clk, reset   clock / async active-low reset
//   push[3:0]    per-lane push strobes; count[k] increments when push[k] is set
//   req, idx     read request and lane select
//   cnt_out      count[idx] as it was in the request cycle (pre-increment)
//   cnt_valid    high the cycle after req; cnt_out holds its value otherwise
module lane_push_counter #(
  parameter int CNT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           push,
  input  logic                 req,
  input  logic [1:0]           idx,
  output logic [CNT_WIDTH-1:0] cnt_out,
  output logic                 cnt_valid
);

  logic [CNT_WIDTH-1:0] count [4];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 4; k++) count[k] <= '0;
      cnt_out   <= '0;
      cnt_valid <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (push[k]) count[k] <= count[k] + CNT_WIDTH'(1);
      end
      cnt_valid <= req;
      // Reads the register before this edge's increment lands.
      if (req) cnt_out <= count[idx];
    end
  end

endmodule

// File: rtl/tlp_ingress_router.sv
// tlp_ingress_router: single-entry stage that routes upstream words to one of
// four input FIFOs by the lane field, with almost-full backpressure and
// per-lane push counters.
//   clk, reset   clock / async active-low reset
//   enable       run enable; 0 stops acceptance (a held word still drains)
//   bus          tlp_ingress_router_if.slave (stream, FIFO side, counter read)
//   state        FSM state for debug
//
// state | meaning
// IDLE  | not accepting; stage word (if any) may still drain
// RUN   | accepting words, full rate when the target FIFO has room
// STALL | stage word blocked by almost-full on its lane; not accepting
module tlp_ingress_router
  import tl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  tlp_ingress_router_if.slave bus,
  output logic [1:0]          state
);

  rtr_state_e            state_q, state_d;
  logic                  stage_vld;
  logic [DATA_WIDTH-1:0] stage_data;
  logic [1:0]            stage_lane;
  logic                  drain;
  logic                  accept;
  logic                  in_ready;
  logic [3:0]            push;

  assign drain    = stage_vld && !bus.alm_full[stage_lane];
  // Depends on stage and alm_full only, never on in_valid.
  assign in_ready = (state_q == RUN) && (!stage_vld || drain);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    push = '0;
    if (drain) push[stage_lane] = 1'b1;
  end

  assign bus.in_ready = in_ready;
  assign bus.push_out = push;
  assign bus.data_out = stage_data;
  assign state        = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_vld  <= 1'b0;
      stage_data <= '0;
      stage_lane <= '0;
    end else if (accept) begin
      stage_vld  <= 1'b1;
      stage_data <= bus.in_data;
      stage_lane <= bus.in_data[LANE_MSB:LANE_LSB];
    end else if (drain) begin
      stage_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (!enable)                                    state_d = IDLE;
        else if (stage_vld && bus.alm_full[stage_lane]) state_d = STALL;
      end
      STALL: begin
        if (drain) state_d = enable ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  lane_push_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .req       (bus.req),
    .idx       (bus.idx),
    .cnt_out   (bus.cnt_out),
    .cnt_valid (bus.cnt_valid)
  );

endmodule

// File: tb/tb_tlp_ingress_router.sv
// Directed bench for tlp_ingress_router: streaming, stall, counter wrap and
// pre-increment readback, enable drop, and async reset during a stall.
module tb_tlp_ingress_router;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [1:0] state;
  int         n_cmp;
  int         n_err;

  tlp_ingress_router_if #(.DATA_WIDTH(10), .CNT_WIDTH(5)) bus ();

  tlp_ingress_router #(.DATA_WIDTH(10), .CNT_WIDTH(5)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .bus    (bus),
    .state  (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset        = 1'b0;
    enable       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.alm_full = '0;
    bus.req      = 1'b0;
    bus.idx      = '0;
    #12;
    reset = 1'b1;
    #1;
    chk("rst_state",     state,         0);
    chk("rst_in_ready",  bus.in_ready,  0);
    chk("rst_push",      bus.push_out,  0);
    chk("rst_data_out",  bus.data_out,  0);
    chk("rst_cnt_out",   bus.cnt_out,   0);
    chk("rst_cnt_valid", bus.cnt_valid, 0);

    // Full-rate stream, one word per lane.
    enable = 1'b1;
    step();
    chk("run_state", state, 1);
    chk("run_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = 10'h000;
    step();
    bus.in_data = 10'h155;
    #1;
    chk("s0_push",  bus.push_out, 4'b0001);
    chk("s0_data",  bus.data_out, 10'h000);
    chk("s0_ready", bus.in_ready, 1);
    step();
    bus.in_data = 10'h2AA;
    #1;
    chk("s1_push",  bus.push_out, 4'b0010);
    chk("s1_data",  bus.data_out, 10'h155);
    chk("s1_ready", bus.in_ready, 1);
    step();
    bus.in_data = 10'h3FF;
    #1;
    chk("s2_push",  bus.push_out, 4'b0100);
    chk("s2_data",  bus.data_out, 10'h2AA);
    chk("s2_ready", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("s3_push", bus.push_out, 4'b1000);
    chk("s3_data", bus.data_out, 10'h3FF);
    step();
    chk("s4_push", bus.push_out, 4'b0000);

    // Stall on lane 1.
    bus.in_valid = 1'b1;
    bus.in_data  = 10'h1A5;
    step();
    bus.in_valid = 1'b0;
    bus.alm_full = 4'b0010;
    #1;
    chk("st0_push",  bus.push_out, 0);
    chk("st0_ready", bus.in_ready, 0);
    step();
    step();
    step();
    chk("st_state", state, 2);
    chk("st_ready", bus.in_ready, 0);
    chk("st_push",  bus.push_out, 0);
    bus.alm_full = 4'b0000;
    #1;
    chk("st_rel_push", bus.push_out, 4'b0010);
    chk("st_rel_data", bus.data_out, 10'h1A5);
    step();
    chk("st_rel_state", state, 1);
    chk("st_after_push", bus.push_out, 0);

    // Clean counters, then 33 pushes to lane 2 (wraps to 1).
    reset = 1'b0;
    #1;
    reset = 1'b1;
    step();
    chk("r2_state", state, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = 10'h200;
    for (int i = 0; i < 33; i++) step();
    bus.in_valid = 1'b0;
    step();
    bus.req = 1'b1;
    bus.idx = 2'd2;
    step();
    bus.req = 1'b0;
    chk("l2_cnt",   bus.cnt_out,   1);
    chk("l2_valid", bus.cnt_valid, 1);

    // Lane 3 to 7, then read in the same cycle as the 8th push.
    bus.in_valid = 1'b1;
    bus.in_data  = 10'h300;
    for (int i = 0; i < 7; i++) step();
    bus.in_valid = 1'b0;
    step();
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.req      = 1'b1;
    bus.idx      = 2'd3;
    #1;
    chk("l3_push", bus.push_out, 4'b1000);
    step();
    bus.req = 1'b0;
    chk("l3_pre_cnt",   bus.cnt_out,   7);
    chk("l3_pre_valid", bus.cnt_valid, 1);
    step();
    chk("l3_hold_valid", bus.cnt_valid, 0);
    chk("l3_hold_cnt",   bus.cnt_out,   7);
    bus.req = 1'b1;
    step();
    bus.req = 1'b0;
    chk("l3_post_cnt", bus.cnt_out, 8);

    // Enable drop with a lane-0 word held.
    bus.in_valid = 1'b1;
    bus.in_data  = 10'h0F0;
    step();
    bus.in_valid = 1'b0;
    enable       = 1'b0;
    #1;
    chk("en_push", bus.push_out, 4'b0001);
    chk("en_data", bus.data_out, 10'h0F0);
    step();
    chk("en_state", state, 0);
    chk("en_ready", bus.in_ready, 0);
    chk("en_push_after", bus.push_out, 0);

    // Async reset while stalled.
    enable = 1'b1;
    step();
    bus.in_valid = 1'b1;
    bus.in_data  = 10'h1A5;
    step();
    bus.in_valid = 1'b0;
    bus.alm_full = 4'b0010;
    step();
    chk("ar_pre_state", state, 2);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_state",     state,         0);
    chk("ar_push",      bus.push_out,  0);
    chk("ar_ready",     bus.in_ready,  0);
    chk("ar_data",      bus.data_out,  0);
    chk("ar_cnt_out",   bus.cnt_out,   0);
    chk("ar_cnt_valid", bus.cnt_valid, 0);
    bus.alm_full = 4'b0000;
    #2;
    reset = 1'b1;
    #1;
    chk("ar_rel_push", bus.push_out, 0);
    step();
    chk("ar_run_state", state, 1);
    chk("ar_run_push",  bus.push_out, 0);
    step();
    chk("ar_run_push2", bus.push_out, 0);
    for (int k = 0; k < 4; k++) begin
      bus.req = 1'b1;
      bus.idx = 2'(k);
      step();
      chk($sformatf("ar_cnt%0d", k), bus.cnt_out, 0);
      chk($sformatf("ar_cnt_valid%0d", k), bus.cnt_valid, 1);
    end
    bus.req = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
